// File: rtl/md_unit_pkg.sv
// Shared constants for the E-stage multiply/divide unit: op encodings and counter width.
// No logic of its own; no latency.
// No flow control here; the md_unit FSM owns backpressure via busy/md_hazard.
package md_unit_pkg;

   localparam int MD_CNT_W = 4;

   // md_op encodings as decoded in D and carried to E
   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   // Multi-cycle ops: the ones that occupy the unit
   function automatic logic is_long_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // Any op this unit executes (long ops plus mthi/mtlo)
   function automatic logic is_md_op(input logic [2:0] op);
      return is_long_op(op) || (op == MD_MTHI) || (op == MD_MTLO);
   endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit product / quotient-remainder from A, B and the op code.
// Zero latency; the caller holds the result in shadow registers.
// No backpressure; div0_o flags a division whose result must not be committed.
module md_calc
   import md_unit_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        div0_o
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] divisor_u;
   logic [31:0] divisor_s;
   logic [31:0] quo_u;
   logic [31:0] rem_u;
   logic [31:0] quo_m;
   logic [31:0] rem_m;

   // Signed division works on magnitudes so INT_MIN / -1 never hits a
   // signed-overflow divide; the wrapped quotient 0x80000000 falls out of the negate.
   assign mag_a     = a_i[31] ? (~a_i + 32'd1) : a_i;
   assign mag_b     = b_i[31] ? (~b_i + 32'd1) : b_i;
   // A zero divisor is swapped for 1 only to keep the divider well defined; div0_o suppresses commit.
   assign divisor_u = (b_i == 32'd0) ? 32'd1 : b_i;
   assign divisor_s = (b_i == 32'd0) ? 32'd1 : mag_b;

   assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
   assign prod_u = {32'd0, a_i} * {32'd0, b_i};
   assign quo_u  = a_i / divisor_u;
   assign rem_u  = a_i % divisor_u;
   assign quo_m  = mag_a / divisor_s;
   assign rem_m  = mag_a % divisor_s;

   // Select the result for the requested op; truncating division, remainder follows dividend sign
   always_comb begin
      hi_o   = 32'd0;
      lo_o   = 32'd0;
      div0_o = 1'b0;
      case (op_i)
         MD_MULT:  {hi_o, lo_o} = prod_s;
         MD_MULTU: {hi_o, lo_o} = prod_u;
         MD_DIV: begin
            lo_o   = (a_i[31] ^ b_i[31]) ? (~quo_m + 32'd1) : quo_m;
            hi_o   = a_i[31] ? (~rem_m + 32'd1) : rem_m;
            div0_o = (b_i == 32'd0);
         end
         MD_DIVU: begin
            lo_o   = quo_u;
            hi_o   = rem_u;
            div0_o = (b_i == 32'd0);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// E-stage mult/div unit holding architectural HI/LO; mthi/mtlo write in one cycle.
// mult commits MULT_CYCLES+1 edges after start, div DIV_CYCLES+1; busy high MULT/DIV_CYCLES cycles.
// No internal queueing: md_hazard_o stalls D; ops arriving while busy are dropped and flagged on md_err_o.
module md_unit
   import md_unit_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        md_en_i,
   input  logic [2:0]  md_op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        busy_o,
   output logic        md_hazard_o,
   output logic        md_err_o
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic [MD_CNT_W-1:0] CNT_MULT = MULT_CYCLES[MD_CNT_W-1:0];
   localparam logic [MD_CNT_W-1:0] CNT_DIV  = DIV_CYCLES[MD_CNT_W-1:0];
   localparam logic [MD_CNT_W-1:0] CNT_ONE  = {{(MD_CNT_W-1){1'b0}}, 1'b1};

   logic [0:0]          state_q, state_d;
   logic [MD_CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]         shadow_hi_q, shadow_hi_d;
   logic [31:0]         shadow_lo_q, shadow_lo_d;
   logic                skip_q, skip_d;
   logic [31:0]         hi_q, hi_d;
   logic [31:0]         lo_q, lo_d;
   logic                err_q, err_d;

   logic [31:0] calc_hi;
   logic [31:0] calc_lo;
   logic        calc_div0;
   logic        start;
   logic        is_div;

   md_calc u_calc (
      .op_i   (md_op_i),
      .a_i    (a_i),
      .b_i    (b_i),
      .hi_o   (calc_hi),
      .lo_o   (calc_lo),
      .div0_o (calc_div0)
   );

   assign start  = md_en_i && is_long_op(md_op_i) && (state_q == ST_IDLE);
   assign is_div = (md_op_i == MD_DIV) || (md_op_i == MD_DIVU);

   // Next-state: latch result at start, count down, commit on the last busy cycle
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shadow_hi_d = shadow_hi_q;
      shadow_lo_d = shadow_lo_q;
      skip_d      = skip_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      err_d       = err_q;
      if (state_q == ST_IDLE) begin
         if (start) begin
            state_d     = ST_BUSY;
            cnt_d       = is_div ? CNT_DIV : CNT_MULT;
            shadow_hi_d = calc_hi;
            shadow_lo_d = calc_lo;
            skip_d      = calc_div0;
         end else if (md_en_i && (md_op_i == MD_MTHI)) begin
            hi_d = a_i;
         end else if (md_en_i && (md_op_i == MD_MTLO)) begin
            lo_d = a_i;
         end
      end else begin
         if (md_en_i && is_md_op(md_op_i)) begin
            err_d = 1'b1;
         end
         if (cnt_q == CNT_ONE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (!skip_q) begin
               hi_d = shadow_hi_q;
               lo_d = shadow_lo_q;
            end
         end else begin
            cnt_d = cnt_q - CNT_ONE;
         end
      end
   end

   // State registers; reset abandons any in-flight op without committing
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         shadow_hi_q <= 32'd0;
         shadow_lo_q <= 32'd0;
         skip_q      <= 1'b0;
         hi_q        <= 32'd0;
         lo_q        <= 32'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shadow_hi_q <= shadow_hi_d;
         shadow_lo_q <= shadow_lo_d;
         skip_q      <= skip_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         err_q       <= err_d;
      end
   end

   assign hi_o        = hi_q;
   assign lo_o        = lo_q;
   assign busy_o      = (state_q == ST_BUSY);
   assign md_hazard_o = start || busy_o;
   assign md_err_o    = err_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: reset, mult/multu/div/divu results, busy length, div0, mthi/mtlo, busy-time ops.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Busy waits are bounded; an expired bound shows up as a wrong busy-cycle count.
module tb_md_unit;
   import md_unit_pkg::*;

   logic        clk;
   logic        reset;
   logic        md_en;
   logic [2:0]  md_op;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        md_hazard;
   logic        md_err;

   int n_cmp = 0;
   int n_bad = 0;
   int nbusy;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .md_en_i     (md_en),
      .md_op_i     (md_op),
      .a_i         (a),
      .b_i         (b),
      .hi_o        (hi),
      .lo_o        (lo),
      .busy_o      (busy),
      .md_hazard_o (md_hazard),
      .md_err_o    (md_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present one op for a single cycle, checking md_hazard before the edge
   task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                        input logic exp_haz, input string tag);
      md_en = 1'b1;
      md_op = op;
      a     = va;
      b     = vb;
      #1;
      check(tag, {31'd0, md_hazard}, {31'd0, exp_haz});
      step();
      md_en = 1'b0;
      md_op = MD_NONE;
   endtask

   // Count busy cycles from the current falling edge, bounded
   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 40) begin
         n++;
         step();
      end
   endtask

   initial begin
      reset = 1'b1;
      md_en = 1'b0;
      md_op = MD_NONE;
      a     = 32'd0;
      b     = 32'd0;
      repeat (2) @(negedge clk);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_err", {31'd0, md_err}, 32'd0);
      check("rst_haz", {31'd0, md_hazard}, 32'd0);
      reset = 1'b0;
      step();

      // mthi/mtlo are single-cycle and never raise busy or hazard
      issue(MD_MTHI, 32'h0000_1234, 32'd0, 1'b0, "mthi_haz");
      check("mthi_hi", hi, 32'h0000_1234);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      issue(MD_MTLO, 32'h0000_5678, 32'd0, 1'b0, "mtlo_haz");
      check("mtlo_lo", lo, 32'h0000_5678);

      // Reset two cycles into a mult: immediate clear, no later commit
      issue(MD_MULT, 32'd3, 32'd4, 1'b1, "rmid_haz");
      check("rmid_busy1", {31'd0, busy}, 32'd1);
      step();
      reset = 1'b1;
      #1;
      check("rmid_busy", {31'd0, busy}, 32'd0);
      check("rmid_hi", hi, 32'd0);
      check("rmid_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (8) step();
      check("rmid_nocommit_hi", hi, 32'd0);
      check("rmid_nocommit_lo", lo, 32'd0);

      // Signed mult -2 * 3 = -6
      issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, "mult_haz");
      wait_idle(nbusy);
      check("mult_cycles", nbusy, 32'd5);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFFA);

      // Unsigned mult 0xFFFFFFFF * 2
      issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, "multu_haz");
      wait_idle(nbusy);
      check("multu_cycles", nbusy, 32'd5);
      check("multu_hi", hi, 32'h0000_0001);
      check("multu_lo", lo, 32'hFFFF_FFFE);

      // Signed div -7 / 2 = -3 rem -1
      issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, "div_haz");
      wait_idle(nbusy);
      check("div_cycles", nbusy, 32'd10);
      check("div_lo", lo, 32'hFFFF_FFFD);
      check("div_hi", hi, 32'hFFFF_FFFF);

      // Unsigned div 4294967289 / 2 = 2147483644 rem 1
      issue(MD_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b1, "divu_haz");
      wait_idle(nbusy);
      check("divu_cycles", nbusy, 32'd10);
      check("divu_lo", lo, 32'h7FFF_FFFC);
      check("divu_hi", hi, 32'h0000_0001);

      // Preload HI, then divide by zero: full busy time, HI/LO untouched
      issue(MD_MTHI, 32'h0000_0011, 32'd0, 1'b0, "mthi2_haz");
      check("mthi2_busy", {31'd0, busy}, 32'd0);
      check("mthi2_hi", hi, 32'h0000_0011);
      issue(MD_DIV, 32'd5, 32'd0, 1'b1, "div0_haz");
      wait_idle(nbusy);
      check("div0_cycles", nbusy, 32'd10);
      check("div0_hi", hi, 32'h0000_0011);
      check("div0_lo", lo, 32'h7FFF_FFFC);

      // Overflow INT_MIN / -1
      issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "ovf_haz");
      wait_idle(nbusy);
      check("ovf_lo", lo, 32'h8000_0000);
      check("ovf_hi", hi, 32'h0000_0000);
      check("ovf_err", {31'd0, md_err}, 32'd0);

      // mtlo while a divu (100/7 = 14 rem 2) is busy: dropped, md_err set
      issue(MD_DIVU, 32'd100, 32'd7, 1'b1, "obusy_haz");
      issue(MD_MTLO, 32'h0000_0055, 32'd0, 1'b1, "obusy_mtlo_haz");
      check("obusy_err", {31'd0, md_err}, 32'd1);
      check("obusy_lo_kept", lo, 32'h8000_0000);
      wait_idle(nbusy);
      check("obusy_cycles", nbusy, 32'd9);
      check("obusy_lo", lo, 32'd14);
      check("obusy_hi", hi, 32'd2);
      check("obusy_err_sticky", {31'd0, md_err}, 32'd1);

      // Back-to-back mult in the first idle cycle: 7 * -3 = -21
      issue(MD_MULT, 32'd7, 32'hFFFF_FFFD, 1'b1, "b2b_haz");
      check("b2b_busy", {31'd0, busy}, 32'd1);
      wait_idle(nbusy);
      check("b2b_cycles", nbusy, 32'd5);
      check("b2b_hi", hi, 32'hFFFF_FFFF);
      check("b2b_lo", lo, 32'hFFFF_FFEB);

      // md_en low ignores the op code
      md_op = MD_MTHI;
      a     = 32'hDEAD_BEEF;
      step();
      md_op = MD_NONE;
      check("en_low_hi", hi, 32'hFFFF_FFFF);
      check("en_low_busy", {31'd0, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- E-stage multiply/divide unit for the 5-stage MIPS pipeline. It executes mult, multu, div, divu, mthi and mtlo, and holds the architectural HI/LO registers.
- It feeds the hazard unit a busy indication. The hazard unit uses it to stall D-stage mult/div/mfhi/mflo/mthi/mtlo instructions until the unit is free.
- mfhi/mflo read the HI/LO outputs combinationally in E.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu after the start cycle (1..15).
- DIV_CYCLES, 10, busy cycles for div/divu after the start cycle (1..15).

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-high reset
- md_en  input  1  E-stage instruction valid (not a bubble or flush)
- md_op  input  3  `MD_NONE/`MD_MULT/`MD_MULTU/`MD_DIV/`MD_DIVU/`MD_MTHI/`MD_MTLO
- A  input  32  forwarded rs value (E)
- B  input  32  forwarded rt value (E)
- HI  output  32  architectural HI
- LO  output  32  architectural LO
- busy  output  1  registered; high while a mult/div is in flight
- md_hazard  output  1  combinational start || busy, consumed by the hazard unit
- md_err  output  1  registered sticky flag: an op arrived while busy

Behaviour:
- Reset is asynchronous and active-high. HI=0, LO=0, busy=0, md_err=0, state=IDLE, counter=0, shadow registers=0. Reset mid-operation aborts the op with no commit.
- start = md_en && md_op in {MULT,MULTU,DIV,DIVU} && state==IDLE.
- FSM states are IDLE and BUSY.
- IDLE to BUSY happens on start. On that edge:
  - shadow_hi/shadow_lo latch the full result, computed combinationally from A/B in the start cycle.
  - counter loads MULT_CYCLES or DIV_CYCLES.
  - busy rises.
- In BUSY, the counter decrements each cycle. When counter==1:
  - the next edge commits shadow to HI/LO;
  - busy falls;
  - state returns to IDLE.
  - The new HI/LO is visible in the first cycle busy is low.
  - Total: mult shows the result MULT_CYCLES+1 edges after the start edge is sampled, i.e. busy is high for exactly MULT_CYCLES cycles.
- mult: {HI,LO} = signed A * signed B, 64-bit. multu: unsigned 64-bit product.
- div/divu: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divide by zero: the op still occupies BUSY for DIV_CYCLES, but no commit; HI/LO are unchanged.
- mthi/mtlo when md_en and IDLE: HI (or LO) := A on the next edge, single cycle, busy stays 0.
- Any md op with md_en while BUSY is ignored: no state change, and md_err sets. The hazard unit must prevent this; md_err is a verification aid.
- md_en=0 ignores md_op entirely.
- md_hazard is high in the start cycle as well, so a dependent instruction in D stalls immediately.
- A new op may start in the same cycle busy has just fallen.

Decomposition:
- Constants go in macro.v: MD_* op encodings (3-bit), MD_CNT_W=4.
- Optional sub-module md_calc: purely combinational A, B, op to 64-bit {hi,lo} plus a div0 flag. The FSM, counter and HI/LO registers stay in md_unit.

Test Plan:
- Reset mid-op: mult issued, reset asserted 2 cycles later → busy=0, HI=LO=0 immediately (asynchronous); the op never commits.
- Signed mult: A=0xFFFFFFFE (-2), B=3, mult → busy for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Unsigned mult: A=0xFFFFFFFF, B=2, multu → HI=1, LO=0xFFFFFFFE after 5 busy cycles.
- Signed div: A=-7 (0xFFFFFFF9), B=2, div → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Repeat with divu → LO=0x7FFFFFFC, HI=1.
- Divide by zero, then mthi/mtlo:
  - Preload HI=0x11 via mthi (1 cycle, busy never high), then div with B=0 → busy for 10 cycles; HI stays 0x11, LO unchanged.
  - Overflow case 0x80000000/−1 → LO=0x80000000, HI=0.
- Op while busy: mtlo with A=0x55 issued while a div is busy → LO unchanged, md_err=1, and the div's result commits normally. A back-to-back mult issued the cycle after busy falls → starts cleanly and md_hazard is high in that cycle.
